// File: rtl/sigma_pkg.sv
// rtl/sigma_pkg.sv - shared ALU op-codes, funct fields and MDU state type
// Purpose: constants and types shared by the execute-stage sequencer and its MDU datapath.
package sigma_pkg;

  // Operation class from main control
  localparam logic [1:0] ALU_OP_TYPE_R_I = 2'b00;
  localparam logic [1:0] ALU_OP_TYPE_LSU = 2'b01;
  localparam logic [1:0] ALU_OP_TYPE_LUI = 2'b10;

  // ALU op-codes
  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_COPY_B = 4'd10;

  // RV32M encodings
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mdu_iter_core.sv
// rtl/mdu_iter_core.sv - one-bit-per-cycle unsigned shift-add multiply / restoring divide datapath
// Purpose: iterates on unsigned operand magnitudes; signs are handled by the caller.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   i_load      capture i_a (multiplier / dividend) and i_b (multiplicand / divisor), clear hi
//   i_step      advance one iteration
//   i_is_div    1 = restoring-divide step, 0 = shift-add multiply step
//   o_hi, o_lo  multiply: {o_hi,o_lo} = product; divide: o_hi = remainder, o_lo = quotient
module mdu_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_step,
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_b;

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN:0]   w_diff;

  // The partial remainder is always below the divisor, so the shifted value is
  // below 2*divisor and XLEN+1 bits hold both it and the trial difference; the
  // top bit of the difference is set exactly when the subtraction borrows.
  always_comb begin
    w_sum    = {1'b0, r_hi} + {1'b0, r_b};
    w_rem_sh = {r_hi, r_lo[XLEN-1]};
    w_diff   = w_rem_sh - {1'b0, r_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
      r_b  <= '0;
    end else if (i_load) begin
      r_hi <= '0;
      r_lo <= i_a;
      r_b  <= i_b;
    end else if (i_step) begin
      if (i_is_div) begin
        if (!w_diff[XLEN]) begin
          r_hi <= w_diff[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], 1'b1};
        end else begin
          r_hi <= w_rem_sh[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], 1'b0};
        end
      end else if (r_lo[0]) begin
        r_hi <= w_sum[XLEN:1];
        r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
      end else begin
        r_hi <= {1'b0, r_hi[XLEN-1:1]};
        r_lo <= {r_hi[0], r_lo[XLEN-1:1]};
      end
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/alu_mdu_sequencer.sv
// rtl/alu_mdu_sequencer.sv - execute-stage ALU decode plus iterative RV32M sequencer
// Purpose: decodes the ALU op-code, issues M-ops to the iterative engine, stalls the
// pipeline while one is in flight and returns the result with a one-cycle pulse.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   alu_op_type_in, is_rtype_in,
//   funct3_in, funct7_in            instruction decode fields
//   alu_op_out, mdu_sel_out         combinational decode results
//   valid_in / ready_out            M-op issue handshake
//   rs1_in, rs2_in                  operands, sampled on the accepting edge
//   flush_in                        abort the in-flight M-op
//   busy_out                        stall request
//   result_out, result_valid_out    M-op result and completion pulse
module alu_mdu_sequencer
  import sigma_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      alu_op_type_in,
  input  logic            is_rtype_in,
  input  logic [2:0]      funct3_in,
  input  logic [6:0]      funct7_in,
  output logic [3:0]      alu_op_out,
  output logic            mdu_sel_out,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [XLEN-1:0] rs1_in,
  input  logic [XLEN-1:0] rs2_in,
  input  logic            flush_in,
  output logic            busy_out,
  output logic [XLEN-1:0] result_out,
  output logic            result_valid_out
);

  localparam int              CW    = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST  = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] W_MIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t      r_state;
  logic [CW-1:0]   r_count;
  logic [2:0]      r_f3;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_special;
  logic [XLEN-1:0] r_special_val;
  logic [XLEN-1:0] r_result;
  logic            r_result_valid;

  logic            w_mdu_sel;
  logic [3:0]      w_alu_op;
  logic            w_accept;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_is_div;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN-1:0] w_spec_val;
  logic            w_step;
  logic [XLEN-1:0] w_hi;
  logic [XLEN-1:0] w_lo;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_fix;

  // Decode
  always_comb begin
    w_mdu_sel = (ENABLE_M != 0) && (alu_op_type_in == ALU_OP_TYPE_R_I) &&
                is_rtype_in && (funct7_in == FUNCT7_MULDIV);
    w_alu_op  = ALU_ADD;
    case (alu_op_type_in)
      ALU_OP_TYPE_R_I: begin
        if (!w_mdu_sel) begin
          case (funct3_in)
            3'b000:  w_alu_op = (is_rtype_in && funct7_in[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  w_alu_op = ALU_SLL;
            3'b010:  w_alu_op = ALU_SLT;
            3'b011:  w_alu_op = ALU_SLTU;
            3'b100:  w_alu_op = ALU_XOR;
            3'b101:  w_alu_op = funct7_in[5] ? ALU_SRA : ALU_SRL;
            3'b110:  w_alu_op = ALU_OR;
            default: w_alu_op = ALU_AND;
          endcase
        end
      end
      ALU_OP_TYPE_LUI: w_alu_op = ALU_COPY_B;
      default:         w_alu_op = ALU_ADD;
    endcase
  end

  assign alu_op_out  = w_alu_op;
  assign mdu_sel_out = w_mdu_sel;

  // Flush wins over a same-cycle accept.
  assign w_accept = valid_in && w_mdu_sel && (r_state == MDU_IDLE) && !flush_in;

  // Operand conditioning on the accepting edge
  always_comb begin
    w_a_signed = (funct3_in == FUNCT3_MUL) || (funct3_in == FUNCT3_MULH) ||
                 (funct3_in == FUNCT3_MULHSU) || (funct3_in == FUNCT3_DIV) ||
                 (funct3_in == FUNCT3_REM);
    w_b_signed = (funct3_in == FUNCT3_MUL) || (funct3_in == FUNCT3_MULH) ||
                 (funct3_in == FUNCT3_DIV) || (funct3_in == FUNCT3_REM);
    w_a_neg    = w_a_signed && rs1_in[XLEN-1];
    w_b_neg    = w_b_signed && rs2_in[XLEN-1];
    w_a_mag    = w_a_neg ? -rs1_in : rs1_in;
    w_b_mag    = w_b_neg ? -rs2_in : rs2_in;
    w_is_div   = funct3_in[2];
    w_div0     = w_is_div && (rs2_in == '0);
    w_ovf      = ((funct3_in == FUNCT3_DIV) || (funct3_in == FUNCT3_REM)) &&
                 (rs1_in == W_MIN) && (rs2_in == '1);
    // funct3[1] separates REM* from DIV*
    if (w_div0) w_spec_val = funct3_in[1] ? rs1_in : '1;
    else        w_spec_val = funct3_in[1] ? '0 : W_MIN;
  end

  assign w_step = ((r_state == MDU_MUL) || (r_state == MDU_DIV)) && !flush_in;

  mdu_iter_core #(.XLEN(XLEN)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_accept),
    .i_step   (w_step),
    .i_is_div (r_state == MDU_DIV),
    .i_a      (w_a_mag),
    .i_b      (w_b_mag),
    .o_hi     (w_hi),
    .o_lo     (w_lo)
  );

  // Sign fixup and result selection, registered in DONE
  always_comb begin
    w_prod   = {w_hi, w_lo};
    w_prod_s = r_neg_q ? -w_prod : w_prod;
    w_quo    = r_neg_q ? -w_lo : w_lo;
    w_rem    = r_neg_r ? -w_hi : w_hi;
    case (r_f3)
      FUNCT3_MUL:                              w_fix = w_prod_s[XLEN-1:0];
      FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU: w_fix = w_prod_s[2*XLEN-1:XLEN];
      FUNCT3_DIV, FUNCT3_DIVU:                 w_fix = w_quo;
      default:                                 w_fix = w_rem;
    endcase
    if (r_special) w_fix = r_special_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= MDU_IDLE;
      r_count        <= '0;
      r_f3           <= '0;
      r_neg_q        <= 1'b0;
      r_neg_r        <= 1'b0;
      r_special      <= 1'b0;
      r_special_val  <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        MDU_IDLE: begin
          if (w_accept) begin
            r_f3          <= funct3_in;
            r_neg_q       <= w_a_neg ^ w_b_neg;
            r_neg_r       <= w_a_neg;
            r_count       <= '0;
            r_special     <= w_div0 || w_ovf;
            r_special_val <= w_spec_val;
            if (w_div0 || w_ovf) r_state <= MDU_DONE;
            else                 r_state <= w_is_div ? MDU_DIV : MDU_MUL;
          end
        end
        MDU_MUL, MDU_DIV: begin
          if (flush_in) begin
            r_state <= MDU_IDLE;
          end else begin
            r_count <= r_count + CW'(1);
            if (r_count == LAST) r_state <= MDU_DONE;
          end
        end
        MDU_DONE: begin
          if (!flush_in) begin
            r_result       <= w_fix;
            r_result_valid <= 1'b1;
          end
          r_state <= MDU_IDLE;
        end
        default: r_state <= MDU_IDLE;
      endcase
    end
  end

  assign ready_out        = (r_state == MDU_IDLE);
  assign busy_out         = (r_state != MDU_IDLE) || (valid_in && w_mdu_sel);
  assign result_out       = r_result;
  assign result_valid_out = r_result_valid;

endmodule

// File: tb/tb_alu_mdu_sequencer.sv
// tb/tb_alu_mdu_sequencer.sv - self-checking bench for alu_mdu_sequencer
module tb_alu_mdu_sequencer;
  import sigma_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  alu_op_type_in = 2'b00;
  logic        is_rtype_in = 1'b0;
  logic [2:0]  funct3_in = 3'b000;
  logic [6:0]  funct7_in = 7'b0;
  logic [3:0]  alu_op_out;
  logic        mdu_sel_out;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [31:0] rs1_in = 32'h0;
  logic [31:0] rs2_in = 32'h0;
  logic        flush_in = 1'b0;
  logic        busy_out;
  logic [31:0] result_out;
  logic        result_valid_out;

  alu_mdu_sequencer #(.XLEN(32), .ENABLE_M(1)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .alu_op_type_in   (alu_op_type_in),
    .is_rtype_in      (is_rtype_in),
    .funct3_in        (funct3_in),
    .funct7_in        (funct7_in),
    .alu_op_out       (alu_op_out),
    .mdu_sel_out      (mdu_sel_out),
    .valid_in         (valid_in),
    .ready_out        (ready_out),
    .rs1_in           (rs1_in),
    .rs2_in           (rs2_in),
    .flush_in         (flush_in),
    .busy_out         (busy_out),
    .result_out       (result_out),
    .result_valid_out (result_valid_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;
  logic chk_en = 1'b0;

  // Model of the engine timeline: accept edge, edge it returns idle, pulse edge.
  int          acc_edge = -1;
  int          end_edge = -1;
  int          pulse_edge = -1;
  logic [31:0] exp_val = 32'h0;
  logic [31:0] last_val = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [4:0] model_dec(input logic [1:0] t, input logic rt,
                                           input logic [2:0] f3, input logic [6:0] f7);
    logic [3:0] tbl [8];
    logic       sel;
    logic [3:0] op;
    tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    sel = (t == 2'b00) && rt && (f7 == 7'b0000001);
    if (t == 2'b10) op = ALU_COPY_B;
    else if (t != 2'b00 || sel) op = ALU_ADD;
    else begin
      op = tbl[f3];
      if (f3 == 3'd0 && rt && f7[5]) op = ALU_SUB;
      if (f3 == 3'd5 && f7[5]) op = ALU_SRA;
    end
    return {sel, op};
  endfunction

  function automatic logic [31:0] model_mdu(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ub, r;
    logic [63:0] up;
    logic [31:0] res;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'h0, b});
    up  = {32'h0, a} * {32'h0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = 0;
    case (f3)
      3'd0: begin r = sa * sb; res = r[31:0]; end
      3'd1: begin r = sa * sb; res = r[63:32]; end
      3'd2: begin r = sa * ub; res = r[63:32]; end
      3'd3: res = up[63:32];
      3'd4: begin
        if (b == 0) res = 32'hFFFF_FFFF;
        else if (ovf) res = 32'h8000_0000;
        else begin r = sa / sb; res = r[31:0]; end
      end
      3'd5: res = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) res = a;
        else if (ovf) res = 32'h0;
        else begin r = sa % sb; res = r[31:0]; end
      end
      default: res = (b == 0) ? a : a % b;
    endcase
    return res;
  endfunction

  // Per-cycle comparison against the model
  logic [4:0] c_dec;
  logic       c_ready, c_busy, c_pulse;
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      c_dec   = model_dec(alu_op_type_in, is_rtype_in, funct3_in, funct7_in);
      c_ready = !(acc_edge >= 0 && cyc >= acc_edge && cyc < end_edge);
      c_busy  = !c_ready || (valid_in && c_dec[4]);
      c_pulse = (cyc == pulse_edge);
      if (c_pulse) last_val = exp_val;
      check("cmp_alu_op", {28'h0, alu_op_out}, {28'h0, c_dec[3:0]});
      check("cmp_mdu_sel", {31'h0, mdu_sel_out}, {31'h0, c_dec[4]});
      check("cmp_ready", {31'h0, ready_out}, {31'h0, c_ready});
      check("cmp_busy", {31'h0, busy_out}, {31'h0, c_busy});
      check("cmp_result_valid", {31'h0, result_valid_out}, {31'h0, c_pulse});
      check("cmp_result", result_out, last_val);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dec_vec(input string name, input logic [1:0] t, input logic rt,
                         input logic [2:0] f3, input logic [6:0] f7,
                         input logic [3:0] op, input logic sel);
    step();
    valid_in = 1'b0;
    alu_op_type_in = t; is_rtype_in = rt; funct3_in = f3; funct7_in = f7;
    #1;
    check({name, "_op"}, {28'h0, alu_op_out}, {28'h0, op});
    check({name, "_sel"}, {31'h0, mdu_sel_out}, {31'h0, sel});
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input int hold);
    int lat;
    step();
    alu_op_type_in = ALU_OP_TYPE_R_I; is_rtype_in = 1'b1;
    funct3_in = f3; funct7_in = 7'b0000001;
    rs1_in = a; rs2_in = b; valid_in = 1'b1;
    lat = (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
    step();
    acc_edge = cyc; end_edge = cyc + lat; pulse_edge = cyc + lat;
    exp_val = model_mdu(f3, a, b);
    repeat (hold) step();
    valid_in = 1'b0;
  endtask

  task automatic finish_op(input string name, input logic [31:0] want);
    int n;
    n = 0;
    while (cyc <= pulse_edge && n < 100) begin
      step();
      n++;
    end
    check(name, result_out, want);
  endtask

  initial begin
    repeat (3) step();
    check("rst_ready", {31'h0, ready_out}, 32'h1);
    check("rst_busy", {31'h0, busy_out}, 32'h0);
    check("rst_result_valid", {31'h0, result_valid_out}, 32'h0);
    check("rst_result", result_out, 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    dec_vec("dec_r_sub",   2'b00, 1'b1, 3'b000, 7'b0100000, ALU_SUB,    1'b0);
    dec_vec("dec_i_add",   2'b00, 1'b0, 3'b000, 7'b0100000, ALU_ADD,    1'b0);
    dec_vec("dec_i_sra",   2'b00, 1'b0, 3'b101, 7'b0100000, ALU_SRA,    1'b0);
    dec_vec("dec_r_srl",   2'b00, 1'b1, 3'b101, 7'b0000000, ALU_SRL,    1'b0);
    dec_vec("dec_r_sltu",  2'b00, 1'b1, 3'b011, 7'b0000000, ALU_SLTU,   1'b0);
    dec_vec("dec_i_and",   2'b00, 1'b0, 3'b111, 7'b0000000, ALU_AND,    1'b0);
    dec_vec("dec_lsu",     2'b01, 1'b1, 3'b101, 7'b0100000, ALU_ADD,    1'b0);
    dec_vec("dec_lui",     2'b10, 1'b0, 3'b001, 7'b0000000, ALU_COPY_B, 1'b0);
    dec_vec("dec_unknown", 2'b11, 1'b1, 3'b100, 7'b0000000, ALU_ADD,    1'b0);
    dec_vec("dec_mop",     2'b00, 1'b1, 3'b101, 7'b0000001, ALU_ADD,    1'b1);
    dec_vec("dec_i_mop",   2'b00, 1'b0, 3'b001, 7'b0000001, ALU_SLL,    1'b0);

    issue(FUNCT3_MUL, 32'd7, 32'hFFFF_FFFD, 0);
    finish_op("mul_7_m3", 32'hFFFF_FFEB);
    issue(FUNCT3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    finish_op("mulhu_max", 32'hFFFF_FFFE);
    issue(FUNCT3_MULH, 32'h8000_0000, 32'h8000_0000, 0);
    finish_op("mulh_min", 32'h4000_0000);
    issue(FUNCT3_MULHSU, 32'hFFFF_FFFF, 32'd2, 0);
    finish_op("mulhsu_m1_2", 32'hFFFF_FFFF);

    issue(FUNCT3_DIVU, 32'd5, 32'd0, 0);
    finish_op("divu_by0", 32'hFFFF_FFFF);
    issue(FUNCT3_REM, 32'd5, 32'd0, 0);
    finish_op("rem_by0", 32'd5);
    issue(FUNCT3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    finish_op("div_ovf", 32'h8000_0000);
    issue(FUNCT3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    finish_op("rem_ovf", 32'h0);

    issue(FUNCT3_DIV, 32'hFFFF_FFF9, 32'd2, 20);
    finish_op("div_m7_2", 32'hFFFF_FFFD);
    issue(FUNCT3_REM, 32'hFFFF_FFF9, 32'd2, 0);
    finish_op("rem_m7_2", 32'hFFFF_FFFF);
    issue(FUNCT3_DIVU, 32'd100, 32'd7, 0);
    finish_op("divu_100_7", 32'd14);
    issue(FUNCT3_REMU, 32'd100, 32'd7, 0);
    finish_op("remu_100_7", 32'd2);
    issue(FUNCT3_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    finish_op("mul_mixed", model_mdu(3'd0, 32'h1234_5678, 32'h9ABC_DEF0));

    // Flush at edge 10 of a multiply
    issue(FUNCT3_MUL, 32'h0000_1234, 32'h0000_5678, 0);
    while (cyc < acc_edge + 9) step();
    flush_in = 1'b1;
    step();
    end_edge = cyc;
    pulse_edge = -1;
    flush_in = 1'b0;
    check("flush_ready", {31'h0, ready_out}, 32'h1);
    repeat (40) step();

    // Flush beats a same-cycle accept
    step();
    funct3_in = FUNCT3_MUL; valid_in = 1'b1; flush_in = 1'b1;
    step();
    valid_in = 1'b0; flush_in = 1'b0;
    check("flush_vs_accept", {31'h0, ready_out}, 32'h1);
    repeat (3) step();

    // Reset in the middle of a divide
    issue(FUNCT3_DIVU, 32'd100, 32'd7, 0);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'h0, ready_out}, 32'h1);
    check("midrst_busy", {31'h0, busy_out}, 32'h0);
    check("midrst_result_valid", {31'h0, result_valid_out}, 32'h0);
    check("midrst_result", result_out, 32'h0);
    acc_edge = -1; end_edge = -1; pulse_edge = -1; last_val = 32'h0;
    step();
    step();
    rst_n = 1'b1;
    repeat (40) step();
    issue(FUNCT3_MUL, 32'd3, 32'd5, 0);
    finish_op("mul_after_reset", 32'd15);
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
